// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output bus among four valid/ready
// requesters, holding each grant for a burst of up to MAX_BURST beats.
module rr_mux_arbiter #(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           i_req_valid,
    input  logic [BUS_WIDTH-1:0] i_req_data_a,
    input  logic [BUS_WIDTH-1:0] i_req_data_b,
    input  logic [BUS_WIDTH-1:0] i_req_data_c,
    input  logic [BUS_WIDTH-1:0] i_req_data_d,
    output logic [3:0]           o_req_ready,
    output logic                 o_out_valid,
    output logic [BUS_WIDTH-1:0] o_out_data,
    output logic [1:0]           o_out_sel,
    input  logic                 i_out_ready
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_grant;
    logic [1:0]           w_grant_nxt;
    logic [1:0]           r_last_grant;
    logic [1:0]           w_last_grant_nxt;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [CNT_W-1:0]     w_beat_cnt_nxt;
    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic [BUS_WIDTH-1:0] r_out_data;
    logic [BUS_WIDTH-1:0] w_out_data_nxt;
    logic [1:0]           r_out_sel;
    logic [1:0]           w_out_sel_nxt;
    logic                 w_out_free;
    logic                 w_xfer;
    logic [BUS_WIDTH-1:0] w_sel_data;

    // Nearest set request searching circularly from last+1; scanning far-to-near lets the nearest win.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        case (r_grant)
            2'd0:    w_sel_data = i_req_data_a;
            2'd1:    w_sel_data = i_req_data_b;
            2'd2:    w_sel_data = i_req_data_c;
            default: w_sel_data = i_req_data_d;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_out_sel_nxt    = r_out_sel;
        o_req_ready      = '0;
        w_out_free       = !r_out_valid || i_out_ready;
        w_xfer           = 1'b0;

        case (r_state)
            IDLE: begin
                if (|i_req_valid) begin
                    w_grant_nxt      = rr_pick(i_req_valid, r_last_grant);
                    w_last_grant_nxt = rr_pick(i_req_valid, r_last_grant);
                    w_beat_cnt_nxt   = '0;
                    w_state_nxt      = BUSY;
                end
            end
            BUSY: begin
                o_req_ready[r_grant] = w_out_free;
                w_xfer = i_req_valid[r_grant] && w_out_free;
                if (!i_req_valid[r_grant]) begin
                    w_state_nxt = IDLE;
                end else if (w_xfer) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A new beat overrides the drain of an accepted one, so there is no bubble.
        if (w_xfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_sel_data;
            w_out_sel_nxt   = r_grant;
        end else if (r_out_valid && i_out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
            r_beat_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sel    <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_sel    <= w_out_sel_nxt;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one instance with MAX_BURST=4, one with
// MAX_BURST=2 for the rotation sequence.
module tb_rr_mux_arbiter;

    localparam int unsigned BW = 4;

    logic          clk;
    logic          rst_n;

    logic [3:0]    a_valid;
    logic [BW-1:0] a_da, a_db, a_dc, a_dd;
    logic [3:0]    a_ready;
    logic          a_ovalid;
    logic [BW-1:0] a_odata;
    logic [1:0]    a_osel;
    logic          a_oready;

    logic [3:0]    b_valid;
    logic [BW-1:0] b_da, b_db, b_dc, b_dd;
    logic [3:0]    b_ready;
    logic          b_ovalid;
    logic [BW-1:0] b_odata;
    logic [1:0]    b_osel;
    logic          b_oready;

    int n_vec;
    int n_err;

    rr_mux_arbiter #(.BUS_WIDTH(BW), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(a_valid),
        .i_req_data_a(a_da), .i_req_data_b(a_db), .i_req_data_c(a_dc), .i_req_data_d(a_dd),
        .o_req_ready(a_ready), .o_out_valid(a_ovalid), .o_out_data(a_odata),
        .o_out_sel(a_osel), .i_out_ready(a_oready)
    );

    rr_mux_arbiter #(.BUS_WIDTH(BW), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(b_valid),
        .i_req_data_a(b_da), .i_req_data_b(b_db), .i_req_data_c(b_dc), .i_req_data_d(b_dd),
        .o_req_ready(b_ready), .o_out_valid(b_ovalid), .o_out_data(b_odata),
        .o_out_sel(b_osel), .i_out_ready(b_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [BW-1:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, 32'(a_ovalid), 32'(v));
        if (v) begin
            chk({tag, "_data"}, 32'(a_odata), 32'(d));
            chk({tag, "_sel"},  32'(a_osel),  32'(s));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_valid = '0; a_da = '0; a_db = '0; a_dc = '0; a_dd = '0; a_oready = 1'b1;
        b_valid = '0; b_da = 4'd1; b_db = 4'd2; b_dc = 4'd3; b_dd = 4'd4; b_oready = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", 32'(a_ovalid), 32'd0);
        chk("rst_data",  32'(a_odata),  32'd0);
        chk("rst_sel",   32'(a_osel),   32'd0);
        chk("rst_ready", 32'(a_ready),  32'd0);
        chk("rst_b_valid", 32'(b_ovalid), 32'd0);
        rst_n = 1'b1;

        // Single requester 1, data 1..6: beats 1-4, one IDLE cycle, beats 5-6
        a_valid = 4'b0010; a_db = 4'd1;
        cyc();
        chk("s1_ready", 32'(a_ready), 32'h2);
        chk_a("s1_lat", 1'b0, 4'd0, 2'd0);
        cyc(); chk_a("s1_b1", 1'b1, 4'd1, 2'd1); a_db = 4'd2;
        cyc(); chk_a("s1_b2", 1'b1, 4'd2, 2'd1); a_db = 4'd3;
        cyc(); chk_a("s1_b3", 1'b1, 4'd3, 2'd1); a_db = 4'd4;
        cyc(); chk_a("s1_b4", 1'b1, 4'd4, 2'd1);
        chk("s1_idle_ready", 32'(a_ready), 32'h0);
        a_db = 4'd5;
        cyc(); chk_a("s1_gap", 1'b0, 4'd0, 2'd0);
        chk("s1_regrant", 32'(a_ready), 32'h2);
        cyc(); chk_a("s1_b5", 1'b1, 4'd5, 2'd1); a_db = 4'd6;
        cyc(); chk_a("s1_b6", 1'b1, 4'd6, 2'd1); a_valid = 4'b0000;
        cyc(); chk_a("s1_end", 1'b0, 4'd0, 2'd0);

        // Backpressure mid-burst on requester 0; accept+transfer overlap afterwards
        a_valid = 4'b0001; a_da = 4'd7;
        cyc(); chk("bp_ready", 32'(a_ready), 32'h1);
        cyc(); chk_a("bp_b1", 1'b1, 4'd7, 2'd0);
        a_da = 4'd8; a_oready = 1'b0; #1;
        chk("bp_stall_ready", 32'(a_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_a("bp_hold", 1'b1, 4'd7, 2'd0);
            chk("bp_hold_ready", 32'(a_ready), 32'h0);
        end
        a_oready = 1'b1; #1;
        chk("bp_release_ready", 32'(a_ready), 32'h1);
        cyc(); chk_a("bp_b2", 1'b1, 4'd8, 2'd0); a_da = 4'd9;
        cyc(); chk_a("bp_b3", 1'b1, 4'd9, 2'd0); a_da = 4'd10;
        cyc(); chk_a("bp_b4", 1'b1, 4'd10, 2'd0);
        a_valid = 4'b0000; #1;
        chk("bp_burst_end_ready", 32'(a_ready), 32'h0);
        cyc(); chk_a("bp_end", 1'b0, 4'd0, 2'd0);

        // Early release: requester 2 gives one beat, requester 3 waiting
        a_valid = 4'b1100; a_dc = 4'd11; a_dd = 4'd12;
        cyc(); chk("er_grant2", 32'(a_ready), 32'h4);
        cyc(); chk_a("er_b2", 1'b1, 4'd11, 2'd2); a_valid = 4'b1000;
        cyc(); chk_a("er_idle", 1'b0, 4'd0, 2'd0);
        chk("er_idle_ready", 32'(a_ready), 32'h0);
        cyc(); chk("er_grant3", 32'(a_ready), 32'h8);
        cyc(); chk_a("er_b3", 1'b1, 4'd12, 2'd3); a_valid = 4'b0000;
        cyc(); chk_a("er_end", 1'b0, 4'd0, 2'd0);

        // Reset during second beat of requester 1, then all requesters valid
        a_valid = 4'b0010; a_db = 4'd13;
        cyc(); chk("rm_grant1", 32'(a_ready), 32'h2);
        cyc(); chk_a("rm_b1", 1'b1, 4'd13, 2'd1);
        a_db = 4'd14; a_da = 4'd5; a_valid = 4'b1111; rst_n = 1'b0;
        cyc();
        chk("rm_valid", 32'(a_ovalid), 32'd0);
        chk("rm_data",  32'(a_odata),  32'd0);
        chk("rm_sel",   32'(a_osel),   32'd0);
        chk("rm_ready", 32'(a_ready),  32'd0);
        rst_n = 1'b1;
        cyc(); chk("rm_grant0", 32'(a_ready), 32'h1);
        cyc(); chk_a("rm_b0", 1'b1, 4'd5, 2'd0);
        a_valid = 4'b0000;
        cyc();

        // Rotation with MAX_BURST=2, all four continuously valid
        b_valid = 4'b1111;
        cyc();
        chk("rr_grant0", 32'(b_ready), 32'h1);
        chk("rr_lat", 32'(b_ovalid), 32'd0);
        for (int r = 0; r < 5; r++) begin
            for (int bt = 0; bt < 2; bt++) begin
                cyc();
                chk("rr_beat_valid", 32'(b_ovalid), 32'd1);
                chk("rr_beat_sel",   32'(b_osel),   32'(r % 4));
                chk("rr_beat_data",  32'(b_odata),  32'(r % 4 + 1));
            end
            if (r < 4) begin
                cyc();
                chk("rr_gap_valid", 32'(b_ovalid), 32'd0);
                chk("rr_next_grant", 32'(b_ready), 32'(4'b0001 << ((r + 1) % 4)));
            end
        end
        b_valid = 4'b0000;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
